// File: rtl/rate_counter.sv
`default_nettype none
// ============================================================================
// Module   : rate_counter
// Purpose  : shared rate divider with four selectable periods, driving a
//            WIDTH-bit up/down modulo counter with parallel load.
//            Optional macro RATE_COUNTER_TC_EN builds the wrap pulse on tc.
// Revision : 1.0 - initial release
// ============================================================================
module rate_counter #(
    parameter int          WIDTH = 4,
    parameter int          DIV_W = 28,
    parameter int unsigned DIV1  = 49_999_999,
    parameter int unsigned DIV2  = 99_999_999,
    parameter int unsigned DIV3  = 199_999_999
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       freq,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic             par_load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    localparam logic [DIV_W-1:0] c_div1 = DIV_W'(DIV1);
    localparam logic [DIV_W-1:0] c_div2 = DIV_W'(DIV2);
    localparam logic [DIV_W-1:0] c_div3 = DIV_W'(DIV3);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       freq_q, freq_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             arm_q, arm_d;

    logic [DIV_W-1:0] w_term;
    logic             w_freq_chg;
    logic             w_div_hit;

    // arm_q keeps tick low from reset until the first edge after release
    always_comb begin
        arm_d      = 1'b1;
        freq_d     = freq;
        w_freq_chg = (freq != freq_q);
        case (freq_q)
            2'd1:    w_term = c_div1;
            2'd2:    w_term = c_div2;
            default: w_term = c_div3;
        endcase
        w_div_hit = (freq_q == 2'd0) || (div_q >= w_term);
        tick      = arm_q && enable && !w_freq_chg && w_div_hit;

        div_d = div_q;
        if (par_load || w_freq_chg || tick) begin
            div_d = '0;
        end else if (enable) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (par_load) begin
            cnt_d = d;
        end else if (tick) begin
            if (up_down) begin
                cnt_d = (cnt_q >= limit) ? '0 : cnt_q + WIDTH'(1);
            end else begin
                cnt_d = ((cnt_q == '0) || (cnt_q > limit)) ? limit : cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            freq_q <= 2'd0;
            cnt_q  <= '0;
            arm_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            freq_q <= freq_d;
            cnt_q  <= cnt_d;
            arm_q  <= arm_d;
        end
    end

    assign q = cnt_q;

`ifdef RATE_COUNTER_TC_EN
    logic tc_q, tc_d;

    // only a genuine wrap (limit->0 up, 0->limit down) flags terminal count
    always_comb begin
        tc_d = 1'b0;
        if (!par_load && tick) begin
            tc_d = up_down ? (cnt_q == limit) : (cnt_q == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`else
    assign tc = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rate_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rate_counter
// Purpose  : scoreboard bench for rate_counter (DIV1=1, DIV2=3, DIV3=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rate_counter;

`ifdef RATE_COUNTER_TC_EN
    localparam bit TC_ON = 1'b1;
`else
    localparam bit TC_ON = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [1:0] freq;
    logic       up_down;
    logic [3:0] limit;
    logic       par_load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tick;
    logic       tc;

    rate_counter #(
        .WIDTH (4),
        .DIV_W (8),
        .DIV1  (1),
        .DIV2  (3),
        .DIV3  (7)
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .freq     (freq),
        .up_down  (up_down),
        .limit    (limit),
        .par_load (par_load),
        .d        (d),
        .q        (q),
        .tick     (tick),
        .tc       (tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tick;
        logic       tc;
        bit         tc_chk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string nm, input int qv, input bit tk,
                              input bit tcv, input bit tcc);
        exp_t e;
        e.name   = nm;
        e.q      = 4'(qv);
        e.tick   = tk;
        e.tc     = tcv & TC_ON;
        e.tc_chk = tcc;
        sb.push_back(e);
    endtask

    // Monitor: every falling edge, check everything issued for this cycle
    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (q !== e.q) begin
                n_bad++;
                $display("FAIL %s.q: got %0d expected %0d", e.name, q, e.q);
            end
            n_cmp++;
            if (tick !== e.tick) begin
                n_bad++;
                $display("FAIL %s.tick: got %b expected %b", e.name, tick, e.tick);
            end
            if (e.tc_chk) begin
                n_cmp++;
                if (tc !== e.tc) begin
                    n_bad++;
                    $display("FAIL %s.tc: got %b expected %b", e.name, tc, e.tc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected end earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; freq = 2'd0; up_down = 1'b1;
        limit = 4'd15; par_load = 1'b0; d = 4'd0;

        next_cycle(); next_cycle();
        expect_out("reset", 0, 0, 0, 1);

        // Rate: freq=2 gives a tick every 4th clock after the freq_q update
        next_cycle();
        reset_n = 1'b1; enable = 1'b1; freq = 2'd2;
        expect_out("release", 0, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            expect_out("rate_div4", (k - 1) / 4, (k % 4) == 0, 0, 1);
        end

        next_cycle(); freq = 2'd0; expect_out("fswitch0", 3, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            expect_out("every_clk", 3 + k, 1, 0, 1);
        end

        // Asynchronous reset between edges
        next_cycle(); #1; reset_n = 1'b0; expect_out("async_rst", 0, 0, 0, 1);
        next_cycle(); expect_out("rst_hold", 0, 0, 0, 1);
        next_cycle(); reset_n = 1'b1; expect_out("post_release", 0, 0, 0, 1);

        // Modulo 9 and wraps
        next_cycle(); limit = 4'd9; par_load = 1'b1; d = 4'd8;
        expect_out("load8", 0, 1, 0, 1);
        next_cycle(); par_load = 1'b0; expect_out("mod_8", 8, 1, 0, 1);
        next_cycle(); expect_out("mod_9", 9, 1, 0, 1);
        next_cycle(); expect_out("mod_wrap", 0, 1, 1, 1);
        next_cycle(); up_down = 1'b0; expect_out("mod_1", 1, 1, 0, 1);
        next_cycle(); expect_out("down_0", 0, 1, 0, 1);

        // Load beyond limit
        next_cycle(); par_load = 1'b1; d = 4'd12; up_down = 1'b1;
        expect_out("down_wrap", 9, 1, 1, 1);
        next_cycle(); par_load = 1'b0; expect_out("load12", 12, 1, 0, 1);
        next_cycle(); par_load = 1'b1; d = 4'd12; expect_out("over_up", 0, 1, 0, 0);
        next_cycle(); par_load = 1'b0; up_down = 1'b0; expect_out("reload12", 12, 1, 0, 1);
        next_cycle(); freq = 2'd1; expect_out("over_down", 9, 0, 0, 0);

        // Load wins over tick; next tick one full period later
        next_cycle(); expect_out("div1_a", 9, 0, 0, 1);
        next_cycle(); par_load = 1'b1; d = 4'd5; up_down = 1'b1;
        expect_out("prio_edge", 9, 1, 0, 1);
        next_cycle(); par_load = 1'b0; expect_out("prio_load", 5, 0, 0, 1);
        next_cycle(); expect_out("prio_next", 5, 1, 0, 1);

        // Frequency switch 3 -> 1 mid-period
        next_cycle(); freq = 2'd3; expect_out("f3_sw", 6, 0, 0, 1);
        next_cycle(); expect_out("f3_run", 6, 0, 0, 1);
        next_cycle(); expect_out("f3_run", 6, 0, 0, 1);
        next_cycle(); freq = 2'd1; expect_out("f31_sw", 6, 0, 0, 1);
        next_cycle(); expect_out("f1_wait", 6, 0, 0, 1);
        next_cycle(); expect_out("f1_tick", 6, 1, 0, 1);
        next_cycle(); expect_out("f1_after", 7, 0, 0, 1);

        // Enable low freezes divider and counter
        next_cycle(); enable = 1'b0; expect_out("freeze_a", 7, 0, 0, 1);
        next_cycle(); expect_out("freeze_b", 7, 0, 0, 1);
        next_cycle(); enable = 1'b1; expect_out("unfreeze", 7, 1, 0, 1);
        next_cycle(); limit = 4'd0; expect_out("resume", 8, 0, 0, 1);

        // limit = 0 keeps q at zero
        next_cycle(); expect_out("lim0_a", 8, 1, 0, 1);
        next_cycle(); expect_out("lim0_b", 0, 0, 0, 0);
        next_cycle(); expect_out("lim0_c", 0, 1, 0, 1);
        next_cycle(); expect_out("lim0_d", 0, 0, 0, 0);

        next_cycle(); next_cycle();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
